// File: rtl/mem_lsu_if.sv
// mem_lsu_if: groups the MEM-stage request/response handshake and the
// data-memory port of the load/store unit.
//   slave  modport : the LSU side (mem_lsu)
//   master modport : the pipeline + data memory side
// Request : req_valid/req_ready, req_we, req_funct3, req_addr, req_wdata
// Response: rsp_valid, rsp_rdata, rsp_fault, stall
// Memory  : dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
//           dmem_rdata, dmem_resp
interface mem_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              dmem_read;
  logic              dmem_write;
  logic [ADDR_W-1:0] dmem_address;
  logic [DATA_W-1:0] dmem_wdata;
  logic [3:0]        dmem_mbe;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_resp;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;
  logic              stall;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  dmem_rdata, dmem_resp,
    output req_ready,
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    output rsp_valid, rsp_rdata, rsp_fault, stall
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output dmem_rdata, dmem_resp,
    input  req_ready,
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    input  rsp_valid, rsp_rdata, rsp_fault, stall
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: RV32I memory-stage load/store unit.
// Accepts one load/store from the MEM stage, performs a word-aligned access
// on the data memory port, and returns the extracted/extended load value
// with a one-cycle completion pulse. Misaligned or illegal ops complete
// immediately with rsp_fault and never touch memory.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-low
//   bus  : mem_lsu_if.slave (request, response, data memory port)
module mem_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  mem_lsu_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nx;

  // Request fields kept for the load extract at response time.
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;

  // Registered memory port and response.
  logic              dmem_read_q;
  logic              dmem_write_q;
  logic [ADDR_W-1:0] dmem_address_q;
  logic [DATA_W-1:0] dmem_wdata_q;
  logic [3:0]        dmem_mbe_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_fault_q;

  // Combinational decode of the incoming request.
  logic              acc_fault;
  logic [3:0]        acc_mbe;
  logic [DATA_W-1:0] acc_wdata;
  logic [1:0]        acc_off;

  // Load extract of the returned word.
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] load_ext;

  function automatic logic op_fault(input logic we, input logic [2:0] f3,
                                    input logic [1:0] off);
    logic f;
    case (f3)
      3'b000:  f = 1'b0;
      3'b001:  f = off[0];
      3'b010:  f = (off != 2'b00);
      3'b100:  f = we;
      3'b101:  f = we | off[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  assign acc_off   = bus.req_addr[1:0];
  assign acc_fault = op_fault(bus.req_we, bus.req_funct3, acc_off);

  always_comb begin
    acc_mbe   = 4'b1111;
    acc_wdata = '0;
    if (bus.req_we) begin
      case (bus.req_funct3)
        3'b000: begin
          acc_mbe   = 4'b0001 << acc_off;
          acc_wdata = {4{bus.req_wdata[7:0]}};
        end
        3'b001: begin
          acc_mbe   = acc_off[1] ? 4'b1100 : 4'b0011;
          acc_wdata = {2{bus.req_wdata[15:0]}};
        end
        default: begin
          acc_mbe   = 4'b1111;
          acc_wdata = bus.req_wdata;
        end
      endcase
    end
  end

  assign rd_shift = bus.dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    load_ext = bus.dmem_rdata;
    case (r_funct3)
      3'b000:  load_ext = {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_ext = {{(DATA_W-8){1'b0}}, rd_shift[7:0]};
      3'b001:  load_ext = {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_ext = {{(DATA_W-16){1'b0}}, rd_shift[15:0]};
      default: load_ext = bus.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nx = acc_fault ? RESP : ACCESS;
      ACCESS:  if (bus.dmem_resp) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory port fields are cleared when the access completes so the port
  // reads idle outside ACCESS; response fields are only nonzero in RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we           <= 1'b0;
      r_funct3       <= '0;
      r_off          <= '0;
      dmem_read_q    <= 1'b0;
      dmem_write_q   <= 1'b0;
      dmem_address_q <= '0;
      dmem_wdata_q   <= '0;
      dmem_mbe_q     <= '0;
      rsp_rdata_q    <= '0;
      rsp_fault_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_funct3    <= bus.req_funct3;
            r_off       <= acc_off;
            rsp_rdata_q <= '0;
            rsp_fault_q <= acc_fault;
            if (!acc_fault) begin
              dmem_read_q    <= ~bus.req_we;
              dmem_write_q   <= bus.req_we;
              dmem_address_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              dmem_wdata_q   <= acc_wdata;
              dmem_mbe_q     <= acc_mbe;
            end
          end
        end
        ACCESS: begin
          if (bus.dmem_resp) begin
            dmem_read_q    <= 1'b0;
            dmem_write_q   <= 1'b0;
            dmem_address_q <= '0;
            dmem_wdata_q   <= '0;
            dmem_mbe_q     <= '0;
            rsp_rdata_q    <= r_we ? '0 : load_ext;
          end
        end
        default: begin
          rsp_rdata_q <= '0;
          rsp_fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready    = (state == IDLE);
  assign bus.dmem_read    = dmem_read_q;
  assign bus.dmem_write   = dmem_write_q;
  assign bus.dmem_address = dmem_address_q;
  assign bus.dmem_wdata   = dmem_wdata_q;
  assign bus.dmem_mbe     = dmem_mbe_q;
  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_rdata    = (state == RESP) ? rsp_rdata_q : '0;
  assign bus.rsp_fault    = (state == RESP) & rsp_fault_q;
  assign bus.stall        = (state == ACCESS) | ((state == IDLE) & bus.req_valid);

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: self-checking bench for mem_lsu. A vector table drives
// loads/stores/faults with a scripted memory responder; expected responses
// go into a scoreboard queue at drive time and are popped by a monitor when
// rsp_valid is seen. Hand-written sequences cover reset, reset during an
// access and a request held through RESP.
module tb_mem_lsu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_word;
    int unsigned dly;
    logic [31:0] e_addr;
    logic [3:0]  e_mbe;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_fault;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mem_word, input int unsigned dly,
                              input logic [31:0] e_addr, input logic [3:0] e_mbe,
                              input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                              input logic e_fault);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.mem_word = mem_word; v.dly = dly; v.e_addr = e_addr; v.e_mbe = e_mbe;
    v.e_wdata = e_wdata; v.e_rdata = e_rdata; v.e_fault = e_fault;
    return v;
  endfunction

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%08h expected no response",
                 bus.rsp_rdata);
      end else begin
        e = sb_q.pop_front();
        check("sb.rsp_rdata", bus.rsp_rdata, e.rdata);
        check("sb.rsp_fault", {31'b0, bus.rsp_fault}, {31'b0, e.fault});
      end
    end
  end

  task automatic drive_req(input vec_t v);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
  endtask

  task automatic idle_req();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
  endtask

  // Runs one op from accept to the RESP cycle; returns at the RESP negedge.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    drive_req(v);
    e.rdata = v.e_rdata;
    e.fault = v.e_fault;
    sb_q.push_back(e);
    #1;
    check({tag, ".ready"}, {31'b0, bus.req_ready}, 32'd1);
    check({tag, ".stall_req"}, {31'b0, bus.stall}, 32'd1);
    @(negedge clk);
    idle_req();
    #1;
    if (v.e_fault) begin
      check({tag, ".f_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
      check({tag, ".f_read"}, {31'b0, bus.dmem_read}, 32'd0);
      check({tag, ".f_write"}, {31'b0, bus.dmem_write}, 32'd0);
      check({tag, ".f_stall"}, {31'b0, bus.stall}, 32'd0);
    end else begin
      for (int unsigned i = 0; i <= v.dly; i++) begin
        if (i > 0) begin
          @(negedge clk);
          #1;
        end
        check({tag, ".read"}, {31'b0, bus.dmem_read}, {31'b0, ~v.we});
        check({tag, ".write"}, {31'b0, bus.dmem_write}, {31'b0, v.we});
        check({tag, ".addr"}, bus.dmem_address, v.e_addr);
        check({tag, ".mbe"}, {28'b0, bus.dmem_mbe}, {28'b0, v.e_mbe});
        check({tag, ".wdata"}, bus.dmem_wdata, v.e_wdata);
        check({tag, ".stall_acc"}, {31'b0, bus.stall}, 32'd1);
        check({tag, ".no_rsp"}, {31'b0, bus.rsp_valid}, 32'd0);
        check({tag, ".rdata_idle"}, bus.rsp_rdata, 32'd0);
        if (i == v.dly) begin
          bus.dmem_resp  = 1'b1;
          bus.dmem_rdata = v.mem_word;
        end
      end
      @(negedge clk);
      bus.dmem_resp  = 1'b0;
      bus.dmem_rdata = 32'hDEAD_BEEF;
      #1;
      check({tag, ".rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
      check({tag, ".read_drop"}, {31'b0, bus.dmem_read}, 32'd0);
      check({tag, ".write_drop"}, {31'b0, bus.dmem_write}, 32'd0);
      check({tag, ".stall_resp"}, {31'b0, bus.stall}, 32'd0);
      check({tag, ".ready_resp"}, {31'b0, bus.req_ready}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    idle_req();
    bus.dmem_resp  = 1'b0;
    bus.dmem_rdata = 32'hDEAD_BEEF;

    //           we    f3      addr          wdata         mem_word      dly e_addr        e_mbe    e_wdata       e_rdata       fault
    tbl.push_back(mk(1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_7F01, 2, 32'h0000_1000, 4'b1111, 32'h0,        32'hFFFF_FF80, 1'b0));
    tbl.push_back(mk(1'b0, 3'b100, 32'h0000_1003, 32'h0,        32'h80FF_7F01, 2, 32'h0000_1000, 4'b1111, 32'h0,        32'h0000_0080, 1'b0));
    tbl.push_back(mk(1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_1234, 1, 32'h0000_2000, 4'b1111, 32'h0,        32'hFFFF_8001, 1'b0));
    tbl.push_back(mk(1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'h8001_1234, 0, 32'h0000_2000, 4'b1111, 32'h0,        32'h0000_8001, 1'b0));
    tbl.push_back(mk(1'b0, 3'b010, 32'h0000_2000, 32'h0,        32'h8001_1234, 1, 32'h0000_2000, 4'b1111, 32'h0,        32'h8001_1234, 1'b0));
    tbl.push_back(mk(1'b0, 3'b100, 32'h0000_2001, 32'h0,        32'h8001_1234, 0, 32'h0000_2000, 4'b1111, 32'h0,        32'h0000_0012, 1'b0));
    tbl.push_back(mk(1'b0, 3'b000, 32'h0000_5000, 32'h0,        32'h1234_567F, 1, 32'h0000_5000, 4'b1111, 32'h0,        32'h0000_007F, 1'b0));
    tbl.push_back(mk(1'b0, 3'b001, 32'h0000_5000, 32'h0,        32'h0000_F00D, 3, 32'h0000_5000, 4'b1111, 32'h0,        32'hFFFF_F00D, 1'b0));
    tbl.push_back(mk(1'b1, 3'b000, 32'h0000_3001, 32'hAABB_CCDD, 32'h5555_5555, 0, 32'h0000_3000, 4'b0010, 32'hDDDD_DDDD, 32'h0,        1'b0));
    tbl.push_back(mk(1'b1, 3'b001, 32'h0000_3002, 32'hAABB_CCDD, 32'h5555_5555, 0, 32'h0000_3000, 4'b1100, 32'hCCDD_CCDD, 32'h0,        1'b0));
    tbl.push_back(mk(1'b1, 3'b010, 32'h0000_3004, 32'hAABB_CCDD, 32'h5555_5555, 1, 32'h0000_3004, 4'b1111, 32'hAABB_CCDD, 32'h0,        1'b0));
    tbl.push_back(mk(1'b1, 3'b001, 32'h0000_5000, 32'h1122_3344, 32'h5555_5555, 2, 32'h0000_5000, 4'b0011, 32'h3344_3344, 32'h0,        1'b0));
    tbl.push_back(mk(1'b1, 3'b000, 32'h0000_5003, 32'h1122_3344, 32'h5555_5555, 0, 32'h0000_5000, 4'b1000, 32'h4444_4444, 32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 3'b010, 32'h0000_4002, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1));
    tbl.push_back(mk(1'b0, 3'b001, 32'h0000_4001, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1));
    tbl.push_back(mk(1'b1, 3'b100, 32'h0000_4000, 32'h1234_5678, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1));
    tbl.push_back(mk(1'b1, 3'b101, 32'h0000_4000, 32'h1234_5678, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1));
    tbl.push_back(mk(1'b0, 3'b011, 32'h0000_4000, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1));
    tbl.push_back(mk(1'b1, 3'b001, 32'h0000_3001, 32'hAABB_CCDD, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1));

    // Reset held two cycles with a request pending.
    v = tbl[0];
    drive_req(v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_req();
    #1;
    check("rst.ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst.read", {31'b0, bus.dmem_read}, 32'd0);
    check("rst.write", {31'b0, bus.dmem_write}, 32'd0);
    check("rst.rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst.stall", {31'b0, bus.stall}, 32'd0);
    check("rst.mbe", {28'b0, bus.dmem_mbe}, 32'd0);
    check("rst.rdata", bus.rsp_rdata, 32'd0);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

    // Request held through RESP must not be taken until the next IDLE cycle.
    v = mk(1'b0, 3'b010, 32'h0000_7000, 32'h0, 32'h0BAD_F00D, 1,
           32'h0000_7000, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b0);
    drive_req(v);
    #1;
    check("b2b.ready_in_resp", {31'b0, bus.req_ready}, 32'd0);
    check("b2b.stall_in_resp", {31'b0, bus.stall}, 32'd0);
    run_vec(v, "b2b");

    // Reset during ACCESS, then a late dmem_resp.
    @(negedge clk);
    drive_req(mk(1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h0, 0,
                 32'h0, 4'b0, 32'h0, 32'h0, 1'b0));
    @(negedge clk);
    idle_req();
    #1;
    check("mid.read", {31'b0, bus.dmem_read}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("mid.read_rst", {31'b0, bus.dmem_read}, 32'd0);
    check("mid.write_rst", {31'b0, bus.dmem_write}, 32'd0);
    check("mid.ready_rst", {31'b0, bus.req_ready}, 32'd1);
    check("mid.stall_rst", {31'b0, bus.stall}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.dmem_resp  = 1'b0;
    bus.dmem_rdata = 32'hDEAD_BEEF;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      check("mid.no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
      check("mid.ready", {31'b0, bus.req_ready}, 32'd1);
      @(negedge clk);
    end

    // A normal op still completes after the aborted access.
    run_vec(tbl[2], "post_rst");
    @(negedge clk);
    check("sb.drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit for the RV32I pipeline.
- Accepts one load or store from the MEM stage and runs the word-aligned handshake with the data memory port. Stalls the pipeline until the access completes.
- Returns the extracted and extended load value that drives the lb/lbu/lh/lhu/lw inputs of the writeback regfile mux.
- Generates byte-lane enables and replicated write data for stores.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width (fixed 4 byte lanes)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low (rst==0 at a rising edge resets)
req_valid  in  1  MEM stage presents a memory op
req_ready  out  1  LSU able to accept (IDLE state)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I width: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  in  ADDR_W  byte address from ALU
req_wdata  in  DATA_W  rs2 value for stores
dmem_read  out  1  memory read strobe
dmem_write  out  1  memory write strobe
dmem_address  out  ADDR_W  word-aligned address, bits [1:0]=00
dmem_wdata  out  DATA_W  lane-replicated store data
dmem_mbe  out  4  byte-lane enables
dmem_rdata  in  DATA_W  read word, valid with dmem_resp
dmem_resp  in  1  access complete
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  extended load data; 0 for stores and faults
rsp_fault  out  1  misaligned or illegal op, qualified by rsp_valid
stall  out  1  hold upstream pipeline registers

Behaviour:
- Reset values: state=IDLE; req_ready=1; all other outputs 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - If req_valid, latch we/funct3/addr/wdata and check the op.
  - Fault conditions: h/hu with addr[0]!=0; w with addr[1:0]!=0; funct3 not in {000,001,010,100,101}; store with funct3 100/101.
  - Fault: go to RESP with rsp_fault=1. No memory strobe is ever raised.
  - Otherwise go to ACCESS.
- ACCESS:
  - Exactly one of dmem_read/dmem_write is high.
  - Strobes and address/wdata/mbe are registered and held stable until dmem_resp.
  - On dmem_resp=1: register the extracted data and go to RESP. Strobes drop the following cycle.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - req_valid is not accepted in RESP.
- stall = (state==ACCESS) | (state==IDLE & req_valid). stall=0 in RESP so the pipeline advances on the rsp_valid cycle.
- Latency:
  - Accept at cycle 0; strobe visible from cycle 1.
  - dmem_resp at cycle N (N>=1) gives rsp_valid at cycle N+1.
  - A fault gives rsp_valid at cycle 1.
- Store lanes (o = addr[1:0]):
  - sb: mbe = 4'b0001<<o; wdata = {4{rs2[7:0]}}.
  - sh: mbe = o[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
  - sw: mbe = 1111; wdata = rs2.
- Loads: mbe=1111, dmem_wdata=0.
- Load extract: s = dmem_rdata >> (8*o).
  - lb: sign-extend s[7:0].
  - lbu: zero-extend s[7:0].
  - lh: sign-extend s[15:0].
  - lhu: zero-extend s[15:0].
  - lw: dmem_rdata.
- rsp_rdata and rsp_fault hold their value only during rsp_valid; they read 0 otherwise.
- dmem_resp in IDLE or RESP is ignored and changes no state.
- Reset asserted mid-ACCESS: next edge returns to IDLE with strobes low. A late dmem_resp after that is ignored.
- dmem_rdata is sampled only in the cycle dmem_resp=1.

Test Plan:
- Reset: hold rst=0 two cycles with req_valid=1 -> req_ready=1, dmem_read=dmem_write=rsp_valid=stall=0 after release before accept.
- lb/lbu at addr 0x1003, memory word 0x80FF_7F01, resp after 3 cycles -> dmem_address=0x1000, mbe=1111; lb gives rsp_rdata=0xFFFF_FF80, lbu gives 0x0000_0080; rsp_valid exactly 1 cycle after resp; stall high throughout ACCESS.
- lh at 0x2002 over word 0x8001_1234 -> 0xFFFF_8001; lhu -> 0x0000_8001; lw at 0x2000 -> 0x8001_1234.
- sb of rs2=0xAABB_CCDD at 0x3001 -> dmem_write=1, mbe=0010, wdata=0xDDDD_DDDD, address 0x3000. sh at 0x3002 -> mbe=1100, wdata=0xCCDD_CCDD. Resp same cycle as strobe -> rsp_valid next cycle, rsp_rdata=0.
- Faults: lw at 0x4002, lh at 0x4001, store funct3=100 -> no strobe ever; rsp_valid at cycle 1 with rsp_fault=1, rsp_rdata=0.
- Reset during ACCESS, then dmem_resp=1 two cycles later -> strobes low after reset edge, no rsp_valid. Back-to-back: next req accepted the cycle after RESP.
